fetch_sequencer: RTL and testbench

- Instruction-fetch controller for the synchronous-read instruction memory.
- Owns the program counter and drives the memory address.
- Absorbs the memory's 1-cycle read latency with a 2-entry instruction buffer.
- Presents instructions to decode over a valid/ready handshake, and accepts PC redirects from branch/jump resolution.

---
 rtl/fetch_sequencer.sv | 87 ++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues reads to a 1-cycle-latency
// memory and queues returning words in a small buffer for decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd4,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic [31:0] ibuf_instr [DEPTH];
  logic [31:0] ibuf_pc    [DEPTH];

  logic        pop;
  logic        issue;
  logic        tail;
  logic [2:0]  occ_after_pop;
  logic [1:0]  count_next;

  assign pop           = if_valid & if_ready;
  assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Issue only when the word it returns is guaranteed a free buffer slot.
  assign issue         = fetch_en & ~redirect_valid & (occ_after_pop < 3'(DEPTH));
  assign count_next    = occ_after_pop[1:0];
  assign tail          = head_q ^ count_q[0];

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = ibuf_instr[head_q];
  assign if_pc     = ibuf_pc[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      misalign_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ibuf_instr[i] <= '0;
        ibuf_pc[i]    <= '0;
      end
    end else begin
      misalign_err <= redirect_valid & (|redirect_pc[1:0]);
      head_q       <= head_q ^ pop;
      if (redirect_valid) begin
        // Flush: the returning word belongs to the abandoned path.
        count_q    <= 2'd0;
        inflight_q <= 1'b0;
        pc_q       <= {redirect_pc[31:2], 2'b00};
      end else begin
        count_q <= count_next;
        if (inflight_q) begin
          ibuf_instr[tail] <= imem_word;
          ibuf_pc[tail]    <= inflight_pc_q;
        end
        if (issue) begin
          inflight_q    <= 1'b1;
          inflight_pc_q <= pc_q;
          pc_q          <= pc_q + 32'd4;
        end else begin
          inflight_q <= 1'b0;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(inflight_q && count_q == 2'd2 && !pop));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected {pc, instr} streams are queued
// whenever fetch is (re)started and popped on every decode handshake.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_word;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbQ[$];
  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;

  fetch_sequencer #(.RESET_PC(32'd4), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_word      (imem_word),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'd4:   return 32'h00100093;
      32'd8:   return 32'h00200113;
      32'd12:  return 32'h00300193;
      32'd32:  return 32'h01F2F313;
      32'h24:  return 32'h01F2E393;
      default: return 32'h5A000000 ^ a;
    endcase
  endfunction

  // Synchronous-read memory: data for the sampled address appears next cycle.
  initial imem_word = 32'h0;
  always @(posedge clk) imem_word <= memWord(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sbRestart(input logic [31:0] start);
    sbQ.delete();
    for (int i = 0; i < 24; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = memWord(e.pc);
      sbQ.push_back(e);
    end
  endtask

  // Drives one cycle of inputs, scores any handshake, then advances past the edge.
  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    exp_t e;
    fetch_en       = fe;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (if_valid && if_ready) begin
      delivered++;
      if (sbQ.size() == 0) begin
        checkOutput("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("if_pc", if_pc, e.pc);
        checkOutput("if_instr", if_instr, e.instr);
      end
    end
    if (rv) sbRestart({rpc[31:2], 2'b00});
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_pc", if_pc, 32'd0);
    checkOutput("rst_instr", if_instr, 32'd0);
    checkOutput("rst_misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd4);

    $display("[TB] reset release and first fetch latency");
    rst_n = 1'b1;
    sbRestart(32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lat_edge1_valid", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lat_edge2_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("first_pc", if_pc, 32'd4);
    checkOutput("first_instr", if_instr, 32'h00100093);

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("bp_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("bp_pc_hold", if_pc, 32'd4);
    end
    checkOutput("bp_addr_frozen", imem_addr, 32'd12);
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp_release_valid", {31'd0, if_valid}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    end

    $display("[TB] redirect while buffer full");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd32);
    checkOutput("rd_flush_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rd_aligned_misalign", {31'd0, misalign_err}, 32'd0);
    checkOutput("rd_addr", imem_addr, 32'd32);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rd_edge1_valid", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rd_edge2_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("rd_pc", if_pc, 32'd32);
    checkOutput("rd_instr", if_instr, 32'h01F2F313);
    stream(4);

    $display("[TB] redirect coincident with pop");
    checkOutput("rdpop_pre_valid", {31'd0, if_valid}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("rdpop_flush_valid", {31'd0, if_valid}, 32'd0);
    stream(6);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h26);
    checkOutput("mis_pulse", {31'd0, misalign_err}, 32'd1);
    checkOutput("mis_addr", imem_addr, 32'h24);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("mis_pc", if_pc, 32'h24);
    checkOutput("mis_instr", if_instr, 32'h01F2E393);
    stream(4);

    $display("[TB] fetch_en low");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fe_drained", {31'd0, if_valid}, 32'd0);
    checkOutput("fe_addr_hold", imem_addr, sbQ[0].pc);
    stream(6);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFFFFF8);
    stream(7);

    $display("[TB] reset mid-stream");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("mid_rst_pc", if_pc, 32'd0);
    checkOutput("mid_rst_addr", imem_addr, 32'd4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sbRestart(32'd4);
    stream(2);
    checkOutput("post_rst_pc", if_pc, 32'd4);
    stream(6);

    checkOutput("delivered_enough", {31'd0, (delivered >= 20)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
